// File: rtl/reglk_pkg.sv
// Shared types and constants for the lock-register bus sequencer.
package reglk_pkg;

  localparam int AW = 32;
  localparam int DW = 32;

  localparam logic [AW-1:0] DEF_LOCK_ADDR  = 32'h0000_0100;
  localparam logic [DW-1:0] DEF_LOCK_VALUE = 32'hFFFF_FFFF;

  localparam logic [2:0] W_BYTE = 3'b000;
  localparam logic [2:0] W_HALF = 3'b001;
  localparam logic [2:0] W_WORD = 3'b010;

  typedef enum logic [1:0] {
    RST_WR = 2'd0,
    RST_RD = 2'd1,
    ARB    = 2'd2,
    FAULT  = 2'd3
  } state_t;

endpackage

// File: rtl/reglk_bus_sequencer_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered last-winner pointer.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_gnt
);

  // Pointer holds the last winner; reset value 1 gives requester 0 first turn.
  logic r_last;

  always_comb begin
    o_gnt = 2'b00;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (i_advance && (o_gnt != 2'b00)) begin
      r_last <= o_gnt[1];
    end
  end

endmodule

// File: rtl/reglk_bus_sequencer.sv
// Restores and verifies the lock register after reset/wake, then round-robins the
// register bus between two requesters, blocking writes to the lock address.
module reglk_bus_sequencer
  import reglk_pkg::*;
#(
  parameter int          NREQ       = 2,
  parameter logic [31:0] LOCK_ADDR  = DEF_LOCK_ADDR,
  parameter logic [31:0] LOCK_VALUE = DEF_LOCK_VALUE,
  parameter logic [2:0]  LOCK_WIDTH = W_WORD,
  parameter int          MAX_RETRY  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pwr_wake,
  input  logic [NREQ-1:0]    m_req,
  input  logic [NREQ-1:0]    m_we,
  input  logic [NREQ*3-1:0]  m_width,
  input  logic [NREQ*AW-1:0] m_addr,
  input  logic [NREQ*DW-1:0] m_wdata,
  output logic [NREQ-1:0]    m_gnt,
  output logic [NREQ-1:0]    m_rvalid,
  output logic [DW-1:0]      m_rdata,
  output logic [NREQ-1:0]    m_err,
  output logic               write_enable,
  output logic [2:0]         mem_width,
  output logic [AW-1:0]      addr,
  output logic [DW-1:0]      write_data,
  input  logic [DW-1:0]      read_data,
  output logic               lock_ok,
  output logic               lock_fault
);

  localparam int RW = $clog2(MAX_RETRY + 1);

  state_t          r_state, w_state_nxt;
  logic            r_chk, w_chk_nxt;
  logic [RW-1:0]   r_retry, w_retry_nxt;
  logic            r_lock_ok, w_lock_ok_nxt;
  logic            r_fault, w_fault_nxt;
  logic            r_we, w_we_nxt;
  logic [2:0]      r_width, w_width_nxt;
  logic [AW-1:0]   r_addr, w_addr_nxt;
  logic [DW-1:0]   r_wdata, w_wdata_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [NREQ-1:0] r_err, w_err_nxt;
  logic [NREQ-1:0] r_rd_pend, w_rd_pend_nxt;
  logic [NREQ-1:0] r_rvalid;
  logic [DW-1:0]   r_rdata;

  logic [NREQ-1:0] w_arb_req, w_arb_gnt;
  logic            w_sel;
  logic            w_sel_we;
  logic [2:0]      w_sel_width;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;

  // A requester whose grant is showing this cycle still holds its old transaction.
  assign w_arb_req = (r_state == ARB) ? (m_req & ~r_gnt) : '0;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (w_arb_req),
    .i_advance (r_state == ARB),
    .o_gnt     (w_arb_gnt)
  );

  assign w_sel       = w_arb_gnt[1];
  assign w_sel_we    = m_we[w_sel];
  assign w_sel_width = w_sel ? m_width[5:3] : m_width[2:0];
  assign w_sel_addr  = w_sel ? m_addr[2*AW-1:AW] : m_addr[AW-1:0];
  assign w_sel_wdata = w_sel ? m_wdata[2*DW-1:DW] : m_wdata[DW-1:0];

  always_comb begin
    w_state_nxt   = r_state;
    w_chk_nxt     = 1'b0;
    w_retry_nxt   = r_retry;
    w_lock_ok_nxt = r_lock_ok;
    w_fault_nxt   = r_fault;
    w_we_nxt      = 1'b0;
    w_width_nxt   = '0;
    w_addr_nxt    = '0;
    w_wdata_nxt   = '0;
    w_gnt_nxt     = '0;
    w_err_nxt     = '0;
    w_rd_pend_nxt = '0;
    case (r_state)
      RST_WR: begin
        if (pwr_wake) begin
          w_retry_nxt = '0;
        end else begin
          w_we_nxt    = 1'b1;
          w_addr_nxt  = LOCK_ADDR;
          w_wdata_nxt = LOCK_VALUE;
          w_width_nxt = LOCK_WIDTH;
          w_state_nxt = RST_RD;
        end
      end
      RST_RD: begin
        // First cycle issues the read; second cycle checks it while it is on the bus.
        if (pwr_wake) begin
          w_state_nxt = RST_WR;
          w_retry_nxt = '0;
        end else if (!r_chk) begin
          w_addr_nxt  = LOCK_ADDR;
          w_width_nxt = LOCK_WIDTH;
          w_chk_nxt   = 1'b1;
        end else if (read_data == LOCK_VALUE) begin
          w_lock_ok_nxt = 1'b1;
          w_retry_nxt   = '0;
          w_state_nxt   = ARB;
        end else if ((int'(r_retry) + 1) < MAX_RETRY) begin
          w_retry_nxt = r_retry + 1'b1;
          w_state_nxt = RST_WR;
        end else begin
          w_lock_ok_nxt = 1'b0;
          w_fault_nxt   = 1'b1;
          w_state_nxt   = FAULT;
        end
      end
      ARB: begin
        w_gnt_nxt = w_arb_gnt;
        if (w_arb_gnt != '0) begin
          if (w_sel_we && (w_sel_addr == LOCK_ADDR) && r_lock_ok) begin
            w_err_nxt = w_arb_gnt;
          end else begin
            w_we_nxt      = w_sel_we;
            w_addr_nxt    = w_sel_addr;
            w_width_nxt   = w_sel_width;
            w_wdata_nxt   = w_sel_we ? w_sel_wdata : '0;
            w_rd_pend_nxt = w_sel_we ? '0 : w_arb_gnt;
          end
        end
        if (pwr_wake) begin
          w_lock_ok_nxt = 1'b0;
          w_retry_nxt   = '0;
          w_state_nxt   = RST_WR;
        end
      end
      FAULT: begin
        w_lock_ok_nxt = 1'b0;
        w_fault_nxt   = 1'b1;
      end
      default: w_state_nxt = FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RST_WR;
      r_chk     <= 1'b0;
      r_retry   <= '0;
      r_lock_ok <= 1'b0;
      r_fault   <= 1'b0;
      r_we      <= 1'b0;
      r_width   <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_gnt     <= '0;
      r_err     <= '0;
      r_rd_pend <= '0;
      r_rvalid  <= '0;
      r_rdata   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_chk     <= w_chk_nxt;
      r_retry   <= w_retry_nxt;
      r_lock_ok <= w_lock_ok_nxt;
      r_fault   <= w_fault_nxt;
      r_we      <= w_we_nxt;
      r_width   <= w_width_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_gnt     <= w_gnt_nxt;
      r_err     <= w_err_nxt;
      r_rd_pend <= w_rd_pend_nxt;
      r_rvalid  <= r_rd_pend;
      r_rdata   <= (r_rd_pend != '0) ? read_data : '0;
    end
  end

  assign m_gnt        = r_gnt;
  assign m_err        = r_err;
  assign m_rvalid     = r_rvalid;
  assign m_rdata      = r_rdata;
  assign write_enable = r_we;
  assign mem_width    = r_width;
  assign addr         = r_addr;
  assign write_data   = r_wdata;
  assign lock_ok      = r_lock_ok;
  assign lock_fault   = r_fault;

endmodule

// File: doc/reglk_bus_sequencer.md
Name: reglk_bus_sequencer

Overview:
- Sits in front of reglk_wrapper and owns its register bus (write_enable, mem_width, addr, write_data, read_data).
- Restores the lock register after reset and after every power-state wake, and verifies it by read-back, before any requester gets access (CWE-1232 mitigation).
- Shares the bus between NREQ requesters with round-robin arbitration.
- Blocks requester writes to the lock register once the lock is restored.

Parameters:
NREQ, 2, number of requesters (fixed 2 in this revision)
LOCK_ADDR, 32'h0000_0100, address of the lock register
LOCK_VALUE, 32'hFFFF_FFFF, value written during restore
LOCK_WIDTH, 3'b010, mem_width code used for restore accesses
MAX_RETRY, 3, restore attempts before fault

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pwr_wake  in  1  one-cycle pulse: exit from low-power state
m_req  in  NREQ  request, held high until m_gnt
m_we  in  NREQ  1=write, 0=read
m_width  in  NREQ x 3  mem_width per requester
m_addr  in  NREQ x 32  address per requester
m_wdata  in  NREQ x 32  write data per requester
m_gnt  out  NREQ  one-hot, one-cycle grant pulse
m_rvalid  out  NREQ  read data valid, one cycle
m_rdata  out  32  read data, shared, qualified by m_rvalid
m_err  out  NREQ  one-cycle pulse: write to LOCK_ADDR blocked
write_enable  out  1  to reglk_wrapper
mem_width  out  3  to reglk_wrapper
addr  out  32  to reglk_wrapper
write_data  out  32  to reglk_wrapper
read_data  in  32  from reglk_wrapper, combinational read
lock_ok  out  1  lock restored and verified
lock_fault  out  1  restore failed MAX_RETRY times

Behaviour:
- **Reset values.** While rst_n is low, every output is 0, the state is RST_WR, retry_cnt is 0, and the round-robin pointer selects requester 0 first.
- **All bus outputs are registered.** When the bus is not in use, write_enable is 0 and addr, write_data and mem_width are 0.
- **State RST_WR.** Drive write_enable=1, addr=LOCK_ADDR, write_data=LOCK_VALUE, mem_width=LOCK_WIDTH for one cycle, then go to RST_RD.
- **State RST_RD.** Drive addr=LOCK_ADDR with write_enable=0 and sample read_data in the same cycle.
  - read_data equals LOCK_VALUE: set lock_ok=1, clear retry_cnt, go to ARB.
  - Mismatch with retry_cnt+1 < MAX_RETRY: increment retry_cnt, go back to RST_WR.
  - Mismatch otherwise: go to FAULT.
- **State ARB, arbitration.** In cycle N the requests are sampled.
  - If one requester is active, it wins.
  - If both are active, the winner is the one not granted last; the pointer updates on every grant.
- **State ARB, access timing.** At N+1 m_gnt[w] pulses and the bus carries the winner's fields.
  - Reads: read_data is captured at N+1, and m_rdata/m_rvalid[w] appear at N+2.
  - Writes return no response.
  - Back-to-back grants are allowed, one per cycle.
  - A requester must drop m_req or present a new transaction the cycle after m_gnt.
- **Lock protection.** A requester write with addr==LOCK_ADDR while lock_ok=1 is still granted, but write_enable stays 0 and m_err[w] pulses together with m_gnt. Reads of LOCK_ADDR are permitted.
- **State FAULT.** Set lock_fault=1 and lock_ok=0. Grant nothing and drive nothing on the bus. Only rst_n exits this state; pwr_wake is ignored.
- **pwr_wake in ARB.** Clear lock_ok in the next cycle and go to RST_WR. A grant issued in the same cycle as pwr_wake still completes, including its rvalid.
- **pwr_wake during RST_WR or RST_RD.** Restart at RST_WR and clear retry_cnt.
- **Requests outside ARB.** They stay pending with no grant and are served in round-robin order after entry to ARB.
- **Reset mid-operation.** Aborts immediately; pending rvalid is discarded.

Decomposition:
- Shared package reglk_pkg holds:
  - the state enum (RST_WR, RST_RD, ARB, FAULT);
  - the address and data width constants;
  - default LOCK_ADDR and LOCK_VALUE;
  - mem_width codes.
- One sub-module: rr_arbiter2, a two-way round-robin arbiter with registered last-grant pointer, inputs req and advance, output one-hot grant.
- FSM, bus mux and lock filter stay in the top.

Test Plan:
- **Reset release, model echoes writes.** Cycle 1: write 0xFFFFFFFF to 0x100. Cycle 2: read 0x100. Cycle 3: lock_ok=1, lock_fault=0; no m_gnt before lock_ok.
- **Read-back stuck at 0x0.** Exactly 3 write/read pairs, then lock_fault=1 and lock_ok=0; m_req held high yields no grant, and pwr_wake does not clear the fault.
- **Both requesters request continuously.**
  - Stimulus: both read distinct addresses, model returns addr+1.
  - Grants alternate 0,1,0,1.
  - m_rdata = addr+1 two cycles after each request sample, with the matching m_rvalid bit.
- **Requester 1 writes 0x0 to 0x100 after lock_ok.** m_gnt[1] and m_err[1] pulse, write_enable stays 0 and the lock value is unchanged; requester 0 reading 0x100 gets 0xFFFFFFFF.
- **pwr_wake during steady traffic, model clears its lock register.**
  - lock_ok drops the next cycle.
  - The restore write and read follow, then lock_ok=1.
  - Pending requests are granted only after that.
  - In-flight rvalid is delivered.
- **pwr_wake in RST_RD after 1 failed attempt.** retry_cnt resets, and 3 more attempts are allowed before fault.
